// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg: control, data and status signals.
// The register drives the slave side; the master side belongs to whoever
// controls the register. Clock and reset are plain module ports.
// Optional feature macro: USR_PARITY_EN adds the Parity status signal.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             Enable;
    logic [2:0]       Mode;
    logic [WIDTH-1:0] D;
    logic             SerIn;
    logic             Start;
    logic [CNT_W-1:0] ShiftCount;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qbar;
    logic             SerOut;
    logic             Busy;
    logic             Done;
`ifdef USR_PARITY_EN
    logic             Parity;

    modport master (
        output Enable, Mode, D, SerIn, Start, ShiftCount,
        input  Q, Qbar, SerOut, Busy, Done, Parity
    );

    modport slave (
        input  Enable, Mode, D, SerIn, Start, ShiftCount,
        output Q, Qbar, SerOut, Busy, Done, Parity
    );
`else
    modport master (
        output Enable, Mode, D, SerIn, Start, ShiftCount,
        input  Q, Qbar, SerOut, Busy, Done
    );

    modport slave (
        input  Enable, Mode, D, SerIn, Start, ShiftCount,
        output Q, Qbar, SerOut, Busy, Done
    );
`endif
endinterface

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit clocked register with load, hold, clear,
// logical/arithmetic shifts and rotates, plus a burst engine that repeats
// a shift/rotate ShiftCount times under a Start/Busy/Done handshake.
// Q/Qbar complementary outputs keep old latch consumers working.
// Optional feature macro: USR_PARITY_EN drives Parity = ^Q.
module universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                  Clk,
    input logic                  Reset,
    universal_shift_reg_if.slave bus
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROTL  = 3'b100;
    localparam logic [2:0] MODE_ROTR  = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic             ser_out_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bmode_q;
    logic             busy_q;
    logic             done_q;

    logic [2:0]       op_mode;
    logic [WIDTH-1:0] q_d;
    logic             ser_out_d;
    logic             burst_req;

    // A Start only launches a burst for the shift/rotate/asr modes; for
    // hold/load/clear it is ignored and the mode acts as a single step.
    assign burst_req = bus.Start && (bus.Mode >= MODE_SHL) && (bus.Mode <= MODE_ASR);

    // One step of the active operation: the captured burst mode while
    // running, otherwise the live Mode input. SerOut only moves when a
    // bit actually leaves the register.
    always_comb begin
        op_mode   = (state_q == ST_RUN) ? bmode_q : bus.Mode;
        q_d       = q_q;
        ser_out_d = ser_out_q;
        case (op_mode)
            MODE_HOLD: begin
                q_d = q_q;
            end
            MODE_LOAD: begin
                q_d = bus.D;
            end
            MODE_SHL: begin
                q_d       = {q_q[WIDTH-2:0], bus.SerIn};
                ser_out_d = q_q[WIDTH-1];
            end
            MODE_SHR: begin
                q_d       = {bus.SerIn, q_q[WIDTH-1:1]};
                ser_out_d = q_q[0];
            end
            MODE_ROTL: begin
                q_d       = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                ser_out_d = q_q[WIDTH-1];
            end
            MODE_ROTR: begin
                q_d       = {q_q[0], q_q[WIDTH-1:1]};
                ser_out_d = q_q[0];
            end
            MODE_ASR: begin
                q_d       = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                ser_out_d = q_q[0];
            end
            MODE_CLEAR: begin
                q_d = '0;
            end
            default: begin
                q_d = q_q;
            end
        endcase
    end

    // Control FSM and datapath state; Busy/Done are registered so they
    // track the state they describe without combinational decode.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            q_q       <= RESET_VAL;
            ser_out_q <= 1'b0;
            cnt_q     <= '0;
            bmode_q   <= MODE_HOLD;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.Enable) begin
                        if (burst_req) begin
                            // Acceptance edge: capture the mode, no step yet.
                            bmode_q <= bus.Mode;
                            if (bus.ShiftCount == '0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                cnt_q   <= bus.ShiftCount;
                                state_q <= ST_RUN;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            q_q       <= q_d;
                            ser_out_q <= ser_out_d;
                        end
                    end
                end
                ST_RUN: begin
                    // Enable low stalls the burst with everything held.
                    if (bus.Enable) begin
                        q_q       <= q_d;
                        ser_out_q <= ser_out_d;
                        cnt_q     <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Done lasts exactly one cycle regardless of Enable.
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q      = q_q;
    assign bus.Qbar   = ~q_q;
    assign bus.SerOut = ser_out_q;
    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;

`ifdef USR_PARITY_EN
    assign bus.Parity = ^q_q;
`endif

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised WIDTH-bit clocked storage register that replaces the single-bit gate-level D latch. It supports parallel load, hold, clear, and logical, arithmetic and rotate shifts.
- A burst engine performs multi-position shifts under a Start/Busy/Done handshake.
- Complementary outputs Q/Qbar are kept, so existing latch consumers can migrate to it.

Parameters:
- WIDTH, 8, register width in bits (>= 2)
- CNT_W, 4, width of the ShiftCount burst-length field
- RESET_VAL, 0, value loaded into Q on reset

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Enable  input  1  clock enable; when low, all state holds
- Mode  input  3  operation select (see Behaviour)
- D  input  WIDTH  parallel load data
- SerIn  input  1  serial fill bit for logical shifts
- Start  input  1  burst request, sampled in IDLE only
- ShiftCount  input  CNT_W  number of burst steps
- Q  output  WIDTH  register contents
- Qbar  output  WIDTH  ~Q, combinational
- SerOut  output  1  registered copy of the last bit shifted or rotated out
- Busy  output  1  high while in RUN
- Done  output  1  one-cycle pulse in DONE

Behaviour:
- Interface: one clock (Clk). Reset is synchronous and active-high (Reset). Every register updates only on the rising edge of Clk.
- Reset has priority over everything, including Enable. On reset: Q=RESET_VAL, SerOut=0, state=IDLE, step counter=0, Busy=0, Done=0.
- Qbar = ~Q at all times, including during reset.
- Mode encoding, per step:
  - 000 hold
  - 001 load D
  - 010 shl: {Q[W-2:0],SerIn}, out=Q[W-1]
  - 011 shr: {SerIn,Q[W-1:1]}, out=Q[0]
  - 100 rotl, out=Q[W-1]
  - 101 rotr, out=Q[0]
  - 110 asr: {Q[W-1],Q[W-1:1]}, out=Q[0]
  - 111 clear: Q=0
- SerOut updates only on shift, rotate or asr steps; otherwise it holds.
- FSM states are IDLE, RUN and DONE.
- IDLE, Enable=1, Start=0: apply Mode for one step on this edge.
- IDLE, Enable=1, Start=1, Mode in 010..110 (burst accepted):
  - Capture Mode into an internal burst-mode register.
  - No step occurs on the acceptance edge.
  - If ShiftCount=0, go to DONE; else load the counter with ShiftCount and go to RUN.
- IDLE, Start=1 with Mode in {000, 001, 111}: Start is ignored and Mode is applied as a single step.
- RUN, Enable=1: perform one step of the captured mode and decrement the counter.
  - If the counter was 1, go to DONE; otherwise stay in RUN.
  - The Mode, D and Start inputs are ignored in RUN. SerIn is sampled live at each step.
- RUN, Enable=0: stall. Q, counter and state hold, and Busy stays high.
- DONE: Done=1 and Busy=0; Q holds; Mode and Start are ignored. Next edge goes to IDLE unconditionally, independent of Enable.
- Latency: for a burst of N>0 (Enable held high), Busy is high for exactly N cycles. Done is asserted in cycle N+1 after acceptance. A new Start is accepted on the cycle after Done at the earliest.
- ShiftCount values greater than WIDTH are legal:
  - rotates wrap modulo WIDTH;
  - shl/shr saturate to an all-SerIn fill;
  - asr saturates to an all-sign fill.
- Reset mid-burst aborts immediately: state=IDLE and no Done pulse.

Optional Feature:
- Macro: USR_PARITY_EN
- Defined: adds output port Parity (1 bit) = ^Q, combinational, so it is 0 during reset when RESET_VAL=0.
- Undefined: the Parity port and its logic are absent; all other behaviour is identical.

Test Plan (all scenarios at WIDTH=8, CNT_W=4, RESET_VAL=0):
- Reset:
  - Stimulus: Reset=1 for one edge with Enable=0.
  - Response: Q=0x00, Qbar=0xFF, SerOut=0, Busy=0, Done=0.
- Load and enable gating:
  - Stimulus: Mode=001, D=0xA5, Enable=1; then Enable=0 with D=0x3C.
  - Response: Q=0xA5 after the first edge and still 0xA5 after the second.
- Rotate-left burst:
  - Stimulus: Q=0x81, Start=1, Mode=100, ShiftCount=3.
  - Response: Q steps 0x03, 0x06, 0x0C; Busy is high for exactly 3 cycles; Done pulses once in the next cycle; SerOut=0.
- Arithmetic shift right, single steps:
  - Stimulus: Q=0x90, Mode=110, two enabled edges.
  - Response: Q=0xC8, then 0xE4; SerOut=0 after each step.
- Burst with stall and abort:
  - Stimulus: Q=0x00, SerIn=1, Start with Mode=010, ShiftCount=5. Drop Enable for 2 cycles after 2 steps, then assert Reset during RUN.
  - Response: Q holds 0x03 and Busy stays high through the stall. On Reset: Q=0x00, Busy=0, and Done is never asserted.
- Zero-length burst and ignored Start:
  - Stimulus: Start with ShiftCount=0, then Start again while in DONE.
  - Response: Done pulses on the cycle after acceptance, Busy is never high, Q is unchanged, and the second Start is ignored.
